piso_ser: RTL and testbench
===========================

Name: piso_ser

Overview:
- Parallel-in/serial-out serializer; sits directly upstream of the serial sequence detector `seq`.
- Accepts a W-bit word via a valid/ready handshake and presents it one bit per clock on `d_out`.
- `d_out` connects straight to the detector's `d` input.
- Holds `d_out` low between frames, so the detector sees a quiet line when no data is being sent.

Parameters:
- W, 8, data word width in bits; legal range W >= 2.
- MSB_FIRST, 1, 1 = bit W-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  parallel word; sampled only on the accepting edge.
- load_valid  input  1  upstream has a word on `din`.
- load_ready  output  1  block can accept a word this cycle.
- d_out  output  1  serial data bit (registered).
- bit_valid  output  1  `d_out` carries a frame bit this cycle (registered).
- busy  output  1  a frame is in progress (state != IDLE).
- done  output  1  one-cycle pulse, high during the last bit of a frame (registered).

Behaviour:
- Reset:
  - `rst` high immediately forces state=IDLE and clears the shift register and count.
  - Output values under reset: `d_out`=0, `bit_valid`=0, `done`=0, `busy`=0, `load_ready`=1.
  - No word is captured while `rst` is high, regardless of `load_valid`.
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress.
  - PAR: present only when SER_PARITY_EN is defined.
- Accept rule: a word is accepted on any rising edge where `load_valid && load_ready`.
  - `din` is copied into an internal shift register; later changes on `din` are ignored.
- `load_ready` is combinational: high in IDLE, and high in the cycle that presents the final frame bit; low otherwise.
- Latency: the first bit appears on `d_out`, with `bit_valid`=1, in the cycle after the accepting edge.
  - Each following edge presents the next bit.
  - A frame occupies exactly W consecutive cycles of `bit_valid`=1.
- Bit order:
  - MSB_FIRST=1: din[W-1], din[W-2] … din[0].
  - MSB_FIRST=0: din[0], din[1] … din[W-1].
- Bit counter: width $clog2(W+1); counts 1..W within the frame; never wraps inside a frame.
- `done` is high exactly in the cycle showing the last frame bit.
- End of frame:
  - If no new word is accepted on that edge: next cycle state=IDLE, `d_out`=0, `bit_valid`=0, `done`=0.
  - If `load_valid` is high during the last-bit cycle, the new word is accepted on that edge and its first bit follows immediately. No idle gap; state stays SHIFT.
- `load_valid` during a non-final SHIFT cycle: ignored (`load_ready`=0); upstream must hold it.
- Reset mid-frame: the frame is aborted with no partial `done`. After release, the block is in IDLE and the next accepted word starts a fresh frame.
- In IDLE, `d_out` is forced to 0, whatever the shift-register contents.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the W data bits, one extra PAR cycle presents the even-parity bit (^word) with `bit_valid`=1. Frame length is W+1.
  - `done` and `load_ready` assert in the PAR cycle, not in the last data-bit cycle.
  - Back-to-back accept in the PAR cycle behaves exactly as in the base design.
  - The parity value is computed from the captured word, not from live `din`.
- Undefined: the PAR state and parity logic are absent; frame length is W.

Test Plan:
- Reset: `rst`=1 with `load_valid`=1, `din`=8'hFF -> `d_out`=0, `bit_valid`=0, `busy`=0, `done`=0, `load_ready`=1; nothing captured after release.
- W=8, MSB_FIRST=1: accept 8'b1001_0001 at edge t -> `d_out` = 1,0,0,1,0,0,0,1 on cycles t+1..t+8; `done` only at t+8; t+9 `d_out`=0, `busy`=0. Chained into `seq`, the detector fires on the embedded 1001.
- Back-to-back: `load_valid` held with 8'hA5 then 8'h3C -> 16 contiguous `bit_valid` cycles 1010_0101_0011_1100; `done` at t+8 and t+16; `load_ready`=0 at t+1..t+7.
- Mid-frame reset: assert `rst` asynchronously after 3 bits of 8'hF0 -> outputs clear in the same cycle without a clock edge. Release, accept 8'h81 -> first bit 1, then 0×6, 1; one `done`.
- MSB_FIRST=0: accept 8'hA5 -> `d_out` = 1,0,1,0,0,1,0,1.
- SER_PARITY_EN: 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1. `done` at t+9 only; `din` changed to 8'hFF after accept does not alter the bits or the parity.

Source files
------------

// File: rtl/piso_ser.sv
// Parallel-in/serial-out serializer feeding the serial sequence detector.
// Optional macro SER_PARITY_EN appends an even-parity bit after the data bits.
module piso_ser #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         d_out,
  output logic         bit_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST     = CW'(W);
  localparam logic [CW-1:0] PRE_LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  state_t         state;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           last_cycle;
  logic           accept;
`ifdef SER_PARITY_EN
  logic           par_bit;
`endif

  // The register always holds the bits still to be sent, pre-aligned so the next one sits at the head.
  function automatic logic head(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] w);
    return MSB_FIRST ? {w[W-2:0], 1'b0} : {1'b0, w[W-1:1]};
  endfunction

`ifdef SER_PARITY_EN
  assign last_cycle = (state == PAR);
`else
  assign last_cycle = (state == SHIFT) && (cnt == LAST);
`endif

  assign load_ready = (state == IDLE) || last_cycle;
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      d_out     <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else if (accept) begin
      state     <= SHIFT;
      shreg     <= advance(din);
      cnt       <= CW'(1);
      d_out     <= head(din);
      bit_valid <= 1'b1;
      done      <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit   <= ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != LAST) begin
            d_out <= head(shreg);
            shreg <= advance(shreg);
            cnt   <= cnt + CW'(1);
`ifdef SER_PARITY_EN
            done  <= 1'b0;
`else
            done  <= (cnt == PRE_LAST);
`endif
          end else begin
`ifdef SER_PARITY_EN
            state <= PAR;
            d_out <= par_bit;
            done  <= 1'b1;
`else
            state     <= IDLE;
            cnt       <= '0;
            d_out     <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          state     <= IDLE;
          cnt       <= '0;
          d_out     <= 1'b0;
          bit_valid <= 1'b0;
          done      <= 1'b0;
        end
`endif
        default: begin
          state     <= IDLE;
          d_out     <= 1'b0;
          bit_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_ser.sv
// Scoreboard bench for piso_ser: one MSB-first and one LSB-first instance share the same stimulus.
module tb_piso_ser;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] din;
  logic         lr_m, d_m, bv_m, busy_m, done_m;
  logic         lr_l, d_l, bv_l, busy_l, done_l;

  int   checks = 0;
  int   errors = 0;
  int   rem = 0;
  exp_t qm[$];
  exp_t ql[$];

  always #5 clk = ~clk;

  piso_ser #(.W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(lr_m),
    .d_out(d_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
  );

  piso_ser #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(lr_l),
    .d_out(d_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic pushFrame(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.last = (i == FL - 1);
      e.b = w[W-1-i];
      qm.push_back(e);
      e.b = w[i];
      ql.push_back(e);
    end
`ifdef SER_PARITY_EN
    e.b = ^w;
    e.last = 1'b1;
    qm.push_back(e);
    ql.push_back(e);
`endif
  endtask

  // Reference model: rem counts frame cycles still to be shown, including the current one.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= 0;
      qm.delete();
      ql.delete();
    end else if (load_valid && rem <= 1) begin
      rem <= FL;
      pushFrame(din);
    end else if (rem != 0) begin
      rem <= rem - 1;
    end
  end

  always @(negedge clk) begin
    exp_t em, el;
    if (rst) begin
      checkOutput("rst_dout", {31'b0, d_m}, 0);
      checkOutput("rst_bit_valid", {31'b0, bv_m}, 0);
      checkOutput("rst_busy", {31'b0, busy_m}, 0);
      checkOutput("rst_done", {31'b0, done_m}, 0);
      checkOutput("rst_load_ready", {31'b0, lr_m}, 1);
      checkOutput("rst_lsb_bit_valid", {31'b0, bv_l}, 0);
    end else begin
      checkOutput("load_ready", {31'b0, lr_m}, {31'b0, rem <= 1});
      checkOutput("lsb_load_ready", {31'b0, lr_l}, {31'b0, rem <= 1});
      checkOutput("busy", {31'b0, busy_m}, {31'b0, rem != 0});
      checkOutput("bit_valid", {31'b0, bv_m}, {31'b0, rem != 0});
      checkOutput("lsb_bit_valid", {31'b0, bv_l}, {31'b0, rem != 0});
      if (rem != 0) begin
        if (qm.size() == 0 || ql.size() == 0) begin
          checkOutput("sb_underflow", qm.size(), 1);
        end else begin
          em = qm.pop_front();
          el = ql.pop_front();
          checkOutput("msb_dout", {31'b0, d_m}, {31'b0, em.b});
          checkOutput("msb_done", {31'b0, done_m}, {31'b0, em.last});
          checkOutput("lsb_dout", {31'b0, d_l}, {31'b0, el.b});
          checkOutput("lsb_done", {31'b0, done_l}, {31'b0, el.last});
        end
      end else begin
        checkOutput("idle_dout", {31'b0, d_m}, 0);
        checkOutput("idle_done", {31'b0, done_m}, 0);
        checkOutput("idle_lsb_dout", {31'b0, d_l}, 0);
      end
    end
  end

  // Holds the word until the model says an edge accepts it, then scrambles din.
  task automatic applyStimulus(input logic [W-1:0] w);
    int n = 0;
    din = w;
    load_valid = 1'b1;
    while (rem > 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) checkOutput("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    din = '1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (rem != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idle_timeout", rem, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b1;
    din = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    load_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    applyStimulus(8'h91);
    waitIdle();

    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    waitIdle();

    applyStimulus(8'hF0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_dout", {31'b0, d_m}, 0);
    checkOutput("async_rst_bit_valid", {31'b0, bv_m}, 0);
    checkOutput("async_rst_busy", {31'b0, busy_m}, 0);
    checkOutput("async_rst_done", {31'b0, done_m}, 0);
    checkOutput("async_rst_load_ready", {31'b0, lr_m}, 1);
    checkOutput("async_rst_lsb_bit_valid", {31'b0, bv_l}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(8'h81);
    waitIdle();

    applyStimulus(8'h07);
    waitIdle();
    applyStimulus(8'hA5);
    waitIdle();

    for (int i = 0; i < 4; i++) applyStimulus(W'($urandom));
    waitIdle();

    checkOutput("sb_drain_msb", qm.size(), 0);
    checkOutput("sb_drain_lsb", ql.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
